// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Parses PS/2 Set-2 scan-code byte streams from the PS/2 byte receiver into
// key events. Handles the E0 extended prefix, the F0 break prefix, the
// E0 12 / E0 59 "fake shift" bytes some keyboards wrap around extended keys,
// and the 8-byte Pause sequence (E1 14 77 E1 F0 14 F0 77). Each complete
// sequence produces one event {code, ext, brk}, which is pushed into a small
// show-ahead FIFO for the application to drain.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rx_done_tick  one-cycle strobe, rx_data holds a new byte
//   rx_data[7:0]  received byte
//   rd_en         pop the head FIFO entry (ignored when empty)
//   clr_ovf       clear the sticky overflow flag
//   key_code[7:0] head entry scan code (0xE1 for Pause)
//   key_ext       head entry had the E0 prefix
//   key_brk       head entry had the F0 prefix (key release)
//   empty         FIFO holds no entries
//   full          FIFO holds 2**FIFO_AW entries
//   overflow      sticky: an event was dropped because the FIFO was full
//
// Handshake: a byte is consumed on every cycle rx_done_tick=1 (the parser
// never back-pressures the receiver). An event is written to the FIFO on the
// same edge as the byte that completes it; if the FIFO is full and no pop
// happens on that edge the event is dropped and overflow is raised. The
// consumer pops with rd_en; a pop only takes effect when empty=0, and the
// head entry is visible on key_* before it is popped (show-ahead).
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int FIFO_AW = 2,
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [7:0] B_E0 = 8'hE0;
    localparam logic [7:0] B_F0 = 8'hF0;
    localparam logic [7:0] B_E1 = 8'hE1;

    typedef enum logic [2:0] {
        IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      pause_cnt;
    logic [TO_W-1:0] to_cnt;

    // Event decode for the byte currently presented on rx_data.
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       ev_fire;

    // FIFO storage and bookkeeping.
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               wr_acc;
    logic               rd_acc;

    // Idle-line / acknowledge bytes that never start a key sequence.
    function automatic logic is_filtered(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Fake shift codes wrapped around extended keys by the keyboard.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == B_E0) || (b == B_F0) || (b == B_E1);
    endfunction

    // -----------------------------------------------------------------------
    // Combinational decode: next state and event for the current byte. Only
    // meaningful on tick cycles; the sequential logic gates it with the tick.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        ev_valid   = 1'b0;
        ev_code    = rx_data;
        ev_ext     = 1'b0;
        ev_brk     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_data == B_E0) begin
                    state_next = S_E0;
                end else if (rx_data == B_F0) begin
                    state_next = S_F0;
                end else if (rx_data == B_E1) begin
                    state_next = S_PAUSE;
                end else if (!is_filtered(rx_data)) begin
                    ev_valid = 1'b1;
                end
            end
            S_E0: begin
                if (rx_data == B_F0) begin
                    state_next = S_E0F0;
                end else if (rx_data == B_E0) begin
                    state_next = S_E0;
                end else if (is_fake_shift(rx_data) || rx_data == B_E1) begin
                    state_next = IDLE;
                end else begin
                    ev_valid   = 1'b1;
                    ev_ext     = 1'b1;
                    state_next = IDLE;
                end
            end
            S_F0: begin
                state_next = IDLE;
                if (!is_prefix(rx_data)) begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                end
            end
            S_E0F0: begin
                state_next = IDLE;
                if (!is_prefix(rx_data) && !is_fake_shift(rx_data)) begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                end
            end
            S_PAUSE: begin
                // Pause bytes carry no information beyond their count.
                if (pause_cnt == 3'd1) begin
                    ev_valid   = 1'b1;
                    ev_code    = B_E1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ev_fire = rx_done_tick && ev_valid;

    // -----------------------------------------------------------------------
    // Parser FSM with inter-byte timeout. The timeout only runs while a
    // sequence is open, so a half-received sequence cannot corrupt the next
    // keystroke after the keyboard glitches or is unplugged.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pause_cnt <= 3'd0;
            to_cnt    <= '0;
        end else if (rx_done_tick) begin
            state  <= state_next;
            to_cnt <= '0;
            if (state == IDLE && rx_data == B_E1) begin
                pause_cnt <= 3'd7;
            end else if (state == S_PAUSE) begin
                pause_cnt <= pause_cnt - 3'd1;
            end
        end else if (state != IDLE) begin
            if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                state     <= IDLE;
                to_cnt    <= '0;
                pause_cnt <= 3'd0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Show-ahead FIFO. A full FIFO still accepts a write when the same edge
    // pops, since the pop frees the slot being written.
    // -----------------------------------------------------------------------
    assign empty  = (count == '0);
    assign full   = (count == (FIFO_AW+1)'(DEPTH));
    assign rd_acc = rd_en && !empty;
    assign wr_acc = ev_fire && (!full || rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                mem[wr_ptr] <= {ev_code, ev_ext, ev_brk};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear wins, so no loss goes unseen.
            if (ev_fire && full && !rd_en) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    assign {key_code, key_ext, key_brk} = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// Testbench for ps2_scancode_decoder. A reference model tracks the open
// prefixes of the current sequence as flags plus a remaining-byte count for
// Pause, and the FIFO as a queue of expected entries. Every cycle the DUT
// status outputs and head entry are compared against the model.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int TIMEOUT = 40;
    localparam int TO_W    = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       empty;
    logic       full;
    logic       overflow;

    ps2_scancode_decoder #(
        .FIFO_AW (FIFO_AW),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rd_en        (rd_en),
        .clr_ovf      (clr_ovf),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_brk      (key_brk),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    bit         m_ovf;
    bit         m_ext;
    bit         m_brk;
    int         m_pause;
    int         gap;
    logic [7:0] byte_q[$];

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit filtered(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    function automatic void model_clear();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_pause = 0;
    endfunction

    // Reference rules for one received byte: returns whether an event
    // completes and its {code, ext, brk}.
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [9:0] ent);
        ev  = 1'b0;
        ent = '0;
        if (gap >= TIMEOUT) model_clear();
        if (m_pause > 0) begin
            m_pause--;
            if (m_pause == 0) begin
                ev  = 1'b1;
                ent = {8'hE1, 2'b00};
            end
        end else if (b == 8'hE1) begin
            if (!m_ext && !m_brk) m_pause = 7;
            else model_clear();
        end else if (b == 8'hE0) begin
            if (m_brk) model_clear();
            else m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            if (m_brk) model_clear();
            else m_brk = 1'b1;
        end else begin
            if (m_ext && (b == 8'h12 || b == 8'h59)) begin
                ev = 1'b0;
            end else if (!m_ext && !m_brk && filtered(b)) begin
                ev = 1'b0;
            end else begin
                ev  = 1'b1;
                ent = {b, m_ext, m_brk};
            end
            model_clear();
        end
    endtask

    task automatic check_outputs();
        check("empty", empty, exp_q.size() == 0);
        check("full", full, exp_q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        if (exp_q.size() > 0) check("head", {key_code, key_ext, key_brk}, exp_q[0]);
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: apply inputs, compare outputs, advance the model.
    task automatic cycle(input bit tick, input logic [7:0] b, input bit rd, input bit clr);
        bit         ev;
        bit         set_ovf;
        logic [9:0] ent;
        rx_done_tick = tick;
        rx_data      = b;
        rd_en        = rd;
        clr_ovf      = clr;
        check_outputs();
        ev = 1'b0;
        ent = '0;
        if (tick) begin
            model_byte(b, ev, ent);
            gap = 0;
        end else begin
            gap++;
        end
        if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
        set_ovf = 1'b0;
        if (ev) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(ent);
            else set_ovf = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
        if (set_ovf) m_ovf = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        rd_en        = 1'b0;
        clr_ovf      = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic send_queue();
        foreach (byte_q[i]) send(byte_q[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop_expect(input string tag, input logic [9:0] exp);
        check(tag, {key_code, key_ext, key_brk}, exp);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        model_clear();
        gap = 0;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 11))
            0:       return 8'hE0;
            1:       return 8'hF0;
            2:       return 8'hE1;
            3:       return 8'h12;
            4:       return 8'h59;
            5:       return 8'hAA;
            6:       return 8'hFA;
            7:       return 8'h00;
            8:       return 8'hE0;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        rd_en        = 1'b0;
        clr_ovf      = 1'b0;
        m_ovf        = 1'b0;
        gap          = 0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state.
        check("rst_key", {key_code, key_ext, key_brk}, 10'h000);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        // Make then break of 0x1C; one-cycle latency to empty=0.
        send(8'h1C);
        check("lat_empty", empty, 1'b0);
        send(8'hF0);
        send(8'h1C);
        pop_expect("a_make", {8'h1C, 2'b00});
        pop_expect("a_break", {8'h1C, 2'b01});
        check("a_drained", empty, 1'b1);

        // Print Screen make and break, fake shifts suppressed.
        byte_q = '{8'hE0, 8'h12, 8'hE0, 8'h7C, 8'hE0, 8'hF0, 8'h7C, 8'hE0, 8'hF0, 8'h12};
        send_queue();
        pop_expect("prtsc_make", {8'h7C, 2'b10});
        pop_expect("prtsc_break", {8'h7C, 2'b11});
        check("prtsc_only2", empty, 1'b1);

        // Pause sequence, then filtered bytes.
        byte_q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA};
        send_queue();
        pop_expect("pause", {8'hE1, 2'b00});
        check("pause_only1", empty, 1'b1);

        // Overflow on the fifth make code.
        byte_q = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        send_queue();
        check("full4", full, 1'b1);
        check("no_ovf4", overflow, 1'b0);
        send(8'h2C);
        check("ovf5", overflow, 1'b1);
        pop_expect("ovf_h0", {8'h15, 2'b00});
        pop_expect("ovf_h1", {8'h1D, 2'b00});
        pop_expect("ovf_h2", {8'h24, 2'b00});
        pop_expect("ovf_h3", {8'h2D, 2'b00});
        check("ovf_drained", empty, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", overflow, 1'b0);

        // Write with pop on a full FIFO.
        byte_q = '{8'h16, 8'h1E, 8'h26, 8'h25};
        send_queue();
        cycle(1'b1, 8'h2E, 1'b1, 1'b0);
        check("rw_full", full, 1'b1);
        check("rw_no_ovf", overflow, 1'b0);
        check("rw_head", {key_code, key_ext, key_brk}, {8'h1E, 2'b00});
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("rw_drained", empty, 1'b1);

        // Inter-byte timeout: full gap aborts E0, shorter gap keeps it.
        send(8'hE0);
        idle(TIMEOUT);
        send(8'h1C);
        pop_expect("to_abort", {8'h1C, 2'b00});
        send(8'hE0);
        idle(TIMEOUT - 2);
        send(8'h1C);
        pop_expect("to_keep", {8'h1C, 2'b10});

        // Reset in the middle of a sequence discards the F0 prefix.
        send(8'h1C);
        send(8'hF0);
        do_reset();
        check("mid_rst_empty", empty, 1'b1);
        send(8'h1C);
        pop_expect("mid_rst", {8'h1C, 2'b00});
        check("mid_rst_only", empty, 1'b0 == 1'b1 ? 1'b0 : (exp_q.size() == 0));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                idle(TIMEOUT + $urandom_range(0, 4));
            end else begin
                cycle($urandom_range(0, 1) == 1, rand_byte(),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            end
        end

        // Drain what is left, bounded.
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("final_empty", empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Downstream consumer of the PS/2 byte receiver. Takes each received byte (rx_done_tick + 8-bit data) and parses PS/2 Set-2 scan-code sequences, including the E0 extended prefix, the F0 break prefix and the 8-byte Pause sequence. It emits one key event per complete sequence (code, extended flag, break flag) into a small show-ahead FIFO read by the application logic.

Parameters:
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (4).
TIMEOUT, 1000000, cycles allowed between bytes of a multi-byte sequence before the parser aborts (10 ms at 100 MHz).
TO_W, 20, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_done_tick  in  1  one-cycle strobe: rx_data holds a new received byte
rx_data  in  8  received byte, valid while rx_done_tick=1
rd_en  in  1  pop head FIFO entry; ignored when empty
clr_ovf  in  1  clears the sticky overflow flag
key_code  out  8  head entry scan code (last byte of sequence; 0xE1 for Pause)
key_ext  out  1  head entry: E0 prefix was present
key_brk  out  1  head entry: F0 prefix was present (key release)
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds 2**FIFO_AW entries
overflow  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset: state=IDLE, timeout counter=0, pause counter=0, FIFO pointers/count=0, empty=1, full=0, overflow=0, key_code=0, key_ext=0, key_brk=0.
- Bytes are processed only on cycles with rx_done_tick=1. The event decode is combinational from state+rx_data. The FIFO write happens on the same clock edge. empty deasserts in the cycle after the tick (latency 1).
- Filtered bytes in IDLE are dropped with no event: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF.
- FSM states and transitions, evaluated on each tick:
  IDLE: E0 -> S_E0; F0 -> S_F0; E1 -> S_PAUSE with pause_cnt=7; filtered byte -> IDLE, dropped; any other byte -> emit (byte,0,0), stay IDLE.
  S_E0: F0 -> S_E0F0; E0 -> stay S_E0; 0x12 or 0x59 (fake shift) -> IDLE, no event; E1 -> IDLE, dropped; other -> emit (byte,1,0) -> IDLE.
  S_F0: E0/F0/E1 -> IDLE, dropped (protocol error); other -> emit (byte,0,1) -> IDLE.
  S_E0F0: 0x12 or 0x59 -> IDLE, no event; E0/F0/E1 -> IDLE, dropped; other -> emit (byte,1,1) -> IDLE.
  S_PAUSE: each tick decrements pause_cnt, byte contents ignored. When the tick arrives with pause_cnt=1: emit (0xE1,0,0) -> IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle with no tick and clears on every tick.
  - When the counter reaches TIMEOUT-1 without a tick: go to IDLE, no event, counter cleared.
  - In IDLE the counter is held at 0.
- FIFO:
  - Show-ahead: key_code/key_ext/key_brk always reflect the head entry while empty=0. Their value while empty=1 is don't-care but stable.
  - rd_en with empty=0 pops at the clock edge.
  - Write and read in the same cycle with 0 < count < depth: count unchanged.
  - Write while full with no rd_en: event dropped, overflow set.
  - Write while full with rd_en=1: read and write both accepted, full stays 1.
  - Read and write when empty: write accepted, read ignored.
  - Pointers wrap modulo depth.
- overflow: set has priority over clr_ovf in the same cycle. Otherwise clr_ovf=1 clears it on the next edge.
- Reset mid-sequence or with FIFO contents: all state discarded immediately; the next byte is parsed from IDLE.

Test Plan:
- Tick 0x1C, then tick F0,1C -> two entries (0x1C,0,0) then (0x1C,0,1). empty=0 one cycle after the first tick; two rd_en pulses -> empty=1.
- Ticks E0,12,E0,7C then E0,F0,7C,E0,F0,12 (Print Screen make/break) -> exactly two entries: (0x7C,1,0), (0x7C,1,1).
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> exactly one entry (0xE1,0,0). Ticks AA, FA -> no entries.
- Five make codes 0x15,0x1D,0x24,0x2D,0x2C with no reads -> full=1 after the fourth, overflow=1, 0x2C dropped. Pop all four in order 15,1D,24,2D. Pulse clr_ovf -> overflow=0. Then write with rd_en on a full FIFO -> both accepted, no overflow.
- Tick E0, idle TIMEOUT cycles, tick 0x1C -> entry (0x1C,0,0), not extended. Repeat with a gap of TIMEOUT-2 cycles -> entry (0x1C,1,0).
- Tick F0, assert reset for 1 cycle, tick 0x1C -> entry (0x1C,0,1) absent; entry (0x1C,0,0) present; FIFO otherwise empty.
